tap_window_monitor: RTL

Downstream consumer of the 3-tap register chain (taps x, y, z, x newest) that the blocking/non-blocking delay stage produces. Each valid cycle it reduces the three taps to a record (sum, maximum, settled flag), buffers records in a small show-ahead FIFO, and presents them on a valid/ready output. It also tracks settled-chain events and sticky overflow, so a bench or host can see when the chain has converged and whether any records were lost.

---
 rtl/tap_window_monitor.sv | 136 +++++++++++++
 1 files changed

// File: rtl/tap_window_monitor.sv
// Reduces the 3-tap delay chain to (sum, max, settled) records, buffers them in a
// show-ahead FIFO and tracks settled-chain events and sticky overflow.
module tap_window_monitor #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          x,
  input  logic [DATA_W-1:0]          y,
  input  logic [DATA_W-1:0]          z,
  input  logic                       in_valid,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [DATA_W+1:0]          out_sum,
  output logic [DATA_W-1:0]          out_max,
  output logic                       out_settled,
  output logic [7:0]                 settled_cnt,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned SW = DATA_W + 2;
  localparam int unsigned RW = SW + DATA_W + 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Stage 1: tap reduction
  logic [DATA_W-1:0] max_xy, max_xyz;
  logic [SW-1:0]     sum_xyz;
  logic              settled_now;

  always_comb begin
    max_xy      = (x > y) ? x : y;
    max_xyz     = (max_xy > z) ? max_xy : z;
    sum_xyz     = {2'b00, x} + {2'b00, y} + {2'b00, z};
    settled_now = (x == y) && (y == z);
  end

  logic              s1_valid_q;
  logic [SW-1:0]     s1_sum_q;
  logic [DATA_W-1:0] s1_max_q;
  logic              s1_settled_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      s1_sum_q     <= '0;
      s1_max_q     <= '0;
      s1_settled_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sum_q     <= sum_xyz;
        s1_max_q     <= max_xyz;
        s1_settled_q <= settled_now;
      end
    end
  end

  // Stage 2: show-ahead FIFO with wrap-bit pointers
  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          full, empty, push, pop, drop;
  logic [RW-1:0] head;

  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    pop   = !empty && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push  = s1_valid_q && (!full || pop);
    drop  = s1_valid_q && full && !pop;
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q[AW-1:0]] <= {s1_sum_q, s1_max_q, s1_settled_q};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Overflow and settled-event tracking
  logic       overflow_q, overflow_d;
  logic       prev_settled_q, prev_settled_d;
  logic [7:0] settled_cnt_q, settled_cnt_d;

  always_comb begin
    overflow_d     = overflow_q | drop;
    prev_settled_d = prev_settled_q;
    settled_cnt_d  = settled_cnt_q;
    if (s1_valid_q) begin
      // Dropped records still advance the edge detector.
      prev_settled_d = s1_settled_q;
      if (s1_settled_q && !prev_settled_q && (settled_cnt_q != 8'hff)) begin
        settled_cnt_d = settled_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q     <= 1'b0;
      prev_settled_q <= 1'b0;
      settled_cnt_q  <= '0;
    end else begin
      overflow_q     <= overflow_d;
      prev_settled_q <= prev_settled_d;
      settled_cnt_q  <= settled_cnt_d;
    end
  end

  // Outputs; storage is not reset, so the head is masked by out_valid.
  always_comb begin
    head        = mem[rptr_q[AW-1:0]];
    out_valid   = !empty;
    out_sum     = out_valid ? head[RW-1 -: SW] : '0;
    out_max     = out_valid ? head[DATA_W:1] : '0;
    out_settled = out_valid ? head[0] : 1'b0;
    settled_cnt = settled_cnt_q;
    overflow    = overflow_q;
    level       = wptr_q - rptr_q;
  end

endmodule
